scb_dispatch_q: RTL and testbench
=================================

// Module: scb_dispatch_q
// PURPOSE
//  Dual-slot dispatch queue directly upstream of the scoreboard. Buffers decoded uop pairs
//  (uops + rd) from the decoder and presents the oldest pair with its slot-order code,
//  holding it until the scoreboard accepts. Decouples decode from scoreboard stalls; flushed by clear.
// PARAMETERS
//  W_PA_REG   5             register address width (rd)
//  W_PD_UOPS  6             uop code width
//  W_PC_SEL_ODR 2           order code width (fixed encoding below)
//  DEPTH      4             pair entries; power of two, >=2
//  W_PTR      2             log2(DEPTH)
//  unused_op  {W_PD_UOPS{1'b1}}  uop driven on an empty slot
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             async active-high reset
//  DCI_PC_vld0   in   1             decoder slot0 valid
//  DCI_PC_vld1   in   1             decoder slot1 valid
//  DCI_PD_uops0  in   W_PD_UOPS     decoder slot0 uop
//  DCI_PD_uops1  in   W_PD_UOPS     decoder slot1 uop
//  DCI_PD_rd0    in   W_PA_REG      decoder slot0 rd
//  DCI_PD_rd1    in   W_PA_REG      decoder slot1 rd
//  DCO_PC_rdy    out  1             queue can take a pair this cycle
//  CDO_PD_uops0  out  W_PD_UOPS     head slot0 uop (older)
//  CDO_PD_uops1  out  W_PD_UOPS     head slot1 uop (younger)
//  CDO_PD_rd0    out  W_PA_REG      head slot0 rd
//  CDO_PD_rd1    out  W_PA_REG      head slot1 rd
//  CDO_PC_odr    out  W_PC_SEL_ODR  head order: 00 empty, 01 slot0 only, 11 both (slot0 older), 10 never
//  CDI_PC_acc    in   1             scoreboard consumes head pair this cycle
//  CFI_PC_clear  in   1             synchronous flush (mispredict/exception)
//  CDO_PC_cnt    out  W_PTR+1       occupied entries
// BEHAVIOUR
//  - Reset (async, rst=1): wptr=rptr=0, cnt=0, storage valid bits 0; outputs odr=00, uops0/1=unused_op,
//    rd0/1=0, rdy=1, cnt=0. Storage data need not be reset.
//  - Enqueue: fire_in = rdy & (vld0|vld1). Stored at wptr on clk edge; visible at head next cycle
//    (1-cycle latency, no same-cycle bypass).
//  - Compaction: vld1 & !vld0 stored as single entry in slot0 (odr 01). vld0 & !vld1 -> odr 01.
//    Both -> odr 11, slot order preserved. Neither -> no enqueue, pointers unchanged.
//  - rdy = (cnt < DEPTH) & !CFI_PC_clear; combinational from registered cnt only (no dependence on acc).
//  - Head outputs driven combinationally from entry[rptr]; empty queue -> odr 00, uops unused_op, rd 0.
//    Empty slot1 of an 01 entry -> uops1=unused_op, rd1=0.
//  - Dequeue: fire_out = CDI_PC_acc & (cnt!=0); rptr++ . acc while empty is ignored.
//  - Head is stable (all CDO_* unchanged) while cnt!=0 and acc=0.
//  - Simultaneous fire_in & fire_out: cnt unchanged, both pointers advance; legal at cnt=DEPTH-1
//    and any cnt>0. At cnt=DEPTH rdy=0 so no enqueue even if acc=1 (next cycle rdy=1).
//  - Pointers wrap modulo DEPTH (W_PTR bits); cnt is W_PTR+1 bits, range 0..DEPTH.
//  - CFI_PC_clear: priority over enqueue and dequeue; next edge wptr=rptr=0, cnt=0; outputs show
//    empty the cycle after. Input pair presented with clear is dropped.
//  - rst asserted mid-operation: immediate empty state regardless of clk; deassert synchronously
//    handled by upstream reset synchronizer.
// TESTING
//  1 Reset: rst=1 mid-stream with cnt=3 -> same cycle odr=00, uops0=6'h3F, cnt=0, rdy=1.
//  2 Fill: enqueue 4 pairs (uops0=1..4, rd0=5..8, both valid), acc=0 -> cnt=4, rdy=0, head uops0=1, odr=11.
//  3 Compaction: vld0=0,vld1=1,uops1=6'h0A,rd1=9 -> next cycle odr=01, uops0=6'h0A, rd0=9, uops1=6'h3F.
//  4 Concurrent: cnt=2, fire_in & acc every cycle for 10 cycles -> cnt stays 2, in-order output, pointer wrap.
//  5 Full+acc: cnt=4, acc=1, vld0=1 -> no enqueue that cycle, cnt=3, rdy=1 next cycle.
//  6 Clear: cnt=3, clear=1 with vld0=1 and acc=1 -> next cycle cnt=0, odr=00; dropped pair never appears.

Source files
------------

// File: rtl/scb_dispatch_q.sv
// Dual-slot dispatch queue feeding the scoreboard.
// Holds decoded uop pairs and presents the oldest pair with its slot-order code.
module scb_dispatch_q #(
  parameter int W_PA_REG     = 5,
  parameter int W_PD_UOPS    = 6,
  parameter int W_PC_SEL_ODR = 2,
  parameter int DEPTH        = 4,
  parameter int W_PTR        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    DCI_PC_vld0,
  input  logic                    DCI_PC_vld1,
  input  logic [W_PD_UOPS-1:0]    DCI_PD_uops0,
  input  logic [W_PD_UOPS-1:0]    DCI_PD_uops1,
  input  logic [W_PA_REG-1:0]     DCI_PD_rd0,
  input  logic [W_PA_REG-1:0]     DCI_PD_rd1,
  output logic                    DCO_PC_rdy,
  output logic [W_PD_UOPS-1:0]    CDO_PD_uops0,
  output logic [W_PD_UOPS-1:0]    CDO_PD_uops1,
  output logic [W_PA_REG-1:0]     CDO_PD_rd0,
  output logic [W_PA_REG-1:0]     CDO_PD_rd1,
  output logic [W_PC_SEL_ODR-1:0] CDO_PC_odr,
  input  logic                    CDI_PC_acc,
  input  logic                    CFI_PC_clear,
  output logic [W_PTR:0]          CDO_PC_cnt
);

  localparam logic [W_PD_UOPS-1:0] UNUSED_OP = '1;
  localparam logic [W_PTR:0]       FULL      = (W_PTR+1)'(DEPTH);
  localparam logic [W_PTR:0]       ONE       = (W_PTR+1)'(1);

  logic [W_PTR-1:0]     r_wptr;
  logic [W_PTR-1:0]     r_rptr;
  logic [W_PTR:0]       r_cnt;
  logic [DEPTH-1:0]     r_vld;
  logic [DEPTH-1:0]     r_two;
  logic [W_PD_UOPS-1:0] r_u0  [DEPTH];
  logic [W_PD_UOPS-1:0] r_u1  [DEPTH];
  logic [W_PA_REG-1:0]  r_rd0 [DEPTH];
  logic [W_PA_REG-1:0]  r_rd1 [DEPTH];

  logic                 w_rdy;
  logic                 w_fire_in;
  logic                 w_fire_out;
  logic                 w_in_two;
  logic [W_PD_UOPS-1:0] w_in_u0;
  logic [W_PD_UOPS-1:0] w_in_u1;
  logic [W_PA_REG-1:0]  w_in_rd0;
  logic [W_PA_REG-1:0]  w_in_rd1;
  logic                 w_hv;
  logic                 w_htwo;

  assign w_rdy      = (r_cnt < FULL) & ~CFI_PC_clear;
  assign w_fire_in  = w_rdy & (DCI_PC_vld0 | DCI_PC_vld1);
  assign w_fire_out = CDI_PC_acc & (r_cnt != '0);

  // A lone slot1 uop is compacted into slot0.
  assign w_in_two = DCI_PC_vld0 & DCI_PC_vld1;
  assign w_in_u0  = DCI_PC_vld0 ? DCI_PD_uops0 : DCI_PD_uops1;
  assign w_in_rd0 = DCI_PC_vld0 ? DCI_PD_rd0 : DCI_PD_rd1;
  assign w_in_u1  = w_in_two ? DCI_PD_uops1 : UNUSED_OP;
  assign w_in_rd1 = w_in_two ? DCI_PD_rd1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      r_two  <= '0;
    end else if (CFI_PC_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      r_two  <= '0;
    end else begin
      if (w_fire_in) begin
        r_wptr         <= r_wptr + 1'b1;
        r_vld[r_wptr]  <= 1'b1;
        r_two[r_wptr]  <= w_in_two;
      end
      if (w_fire_out) begin
        r_rptr         <= r_rptr + 1'b1;
        r_vld[r_rptr]  <= 1'b0;
      end
      if (w_fire_in & ~w_fire_out)
        r_cnt <= r_cnt + ONE;
      else if (~w_fire_in & w_fire_out)
        r_cnt <= r_cnt - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire_in) begin
      r_u0[r_wptr]  <= w_in_u0;
      r_u1[r_wptr]  <= w_in_u1;
      r_rd0[r_wptr] <= w_in_rd0;
      r_rd1[r_wptr] <= w_in_rd1;
    end
  end

  assign w_hv   = r_vld[r_rptr];
  assign w_htwo = w_hv & r_two[r_rptr];

  assign DCO_PC_rdy   = w_rdy;
  assign CDO_PC_cnt   = r_cnt;
  assign CDO_PC_odr   = {w_htwo, w_hv};
  assign CDO_PD_uops0 = w_hv ? r_u0[r_rptr] : UNUSED_OP;
  assign CDO_PD_rd0   = w_hv ? r_rd0[r_rptr] : '0;
  assign CDO_PD_uops1 = w_htwo ? r_u1[r_rptr] : UNUSED_OP;
  assign CDO_PD_rd1   = w_htwo ? r_rd1[r_rptr] : '0;

endmodule

// File: tb/tb_scb_dispatch_q.sv
// Directed bench for scb_dispatch_q.
// Hand-computed expectations for reset, fill, compaction, concurrency, clear.
module tb_scb_dispatch_q;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld0, vld1;
  logic [5:0] u0, u1;
  logic [4:0] rd0, rd1;
  logic       rdy;
  logic [5:0] ou0, ou1;
  logic [4:0] ord0, ord1;
  logic [1:0] odr;
  logic       acc, clr;
  logic [2:0] cnt;

  int checks = 0;
  int errors = 0;

  scb_dispatch_q dut (
    .clk          (clk),
    .rst          (rst),
    .DCI_PC_vld0  (vld0),
    .DCI_PC_vld1  (vld1),
    .DCI_PD_uops0 (u0),
    .DCI_PD_uops1 (u1),
    .DCI_PD_rd0   (rd0),
    .DCI_PD_rd1   (rd1),
    .DCO_PC_rdy   (rdy),
    .CDO_PD_uops0 (ou0),
    .CDO_PD_uops1 (ou1),
    .CDO_PD_rd0   (ord0),
    .CDO_PD_rd1   (ord1),
    .CDO_PC_odr   (odr),
    .CDI_PC_acc   (acc),
    .CFI_PC_clear (clr),
    .CDO_PC_cnt   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld0 = 0; vld1 = 0; acc = 0; clr = 0;
  endtask

  initial begin
    logic [5:0] eu;
    rst = 1; idle();
    u0 = '0; u1 = '0; rd0 = '0; rd1 = '0;
    step();
    chk("rst_odr", odr, 2'b00);
    chk("rst_u0", ou0, 6'h3F);
    chk("rst_u1", ou1, 6'h3F);
    chk("rst_rd0", ord0, 5'd0);
    chk("rst_cnt", cnt, 3'd0);
    chk("rst_rdy", rdy, 1'b1);
    step();
    rst = 0;

    // fill with four dual pairs
    for (int i = 1; i <= 4; i++) begin
      vld0 = 1; vld1 = 1;
      u0 = 6'(i); u1 = 6'(i + 16);
      rd0 = 5'(i + 4); rd1 = 5'(i + 20);
      step();
    end
    idle();
    chk("fill_cnt", cnt, 3'd4);
    chk("fill_rdy", rdy, 1'b0);
    chk("fill_u0", ou0, 6'd1);
    chk("fill_u1", ou1, 6'd17);
    chk("fill_rd0", ord0, 5'd5);
    chk("fill_rd1", ord1, 5'd21);
    chk("fill_odr", odr, 2'b11);
    step();
    chk("hold_u0", ou0, 6'd1);
    chk("hold_cnt", cnt, 3'd4);

    // full with acc: dequeue only
    acc = 1; vld0 = 1; u0 = 6'd30;
    step();
    idle();
    chk("full_cnt", cnt, 3'd3);
    chk("full_rdy", rdy, 1'b1);
    chk("full_u0", ou0, 6'd2);

    // async reset mid-stream, no clock edge
    #2 rst = 1;
    #1;
    chk("arst_odr", odr, 2'b00);
    chk("arst_u0", ou0, 6'h3F);
    chk("arst_cnt", cnt, 3'd0);
    chk("arst_rdy", rdy, 1'b1);
    step();
    rst = 0;

    // compaction of a lone slot1 uop
    vld1 = 1; u1 = 6'h0A; rd1 = 5'd9; u0 = 6'h15; rd0 = 5'd3;
    #1;
    chk("nobyp_odr", odr, 2'b00);
    step();
    idle();
    chk("cmp_odr", odr, 2'b01);
    chk("cmp_u0", ou0, 6'h0A);
    chk("cmp_rd0", ord0, 5'd9);
    chk("cmp_u1", ou1, 6'h3F);
    chk("cmp_rd1", ord1, 5'd0);
    chk("cmp_cnt", cnt, 3'd1);
    vld0 = 1; u0 = 6'h0C; rd0 = 5'd12; u1 = 6'h22;
    step();
    idle();
    step();
    chk("none_cnt", cnt, 3'd2);
    chk("none_u0", ou0, 6'h0A);

    // concurrent enqueue/dequeue across pointer wrap
    for (int k = 0; k < 10; k++) begin
      vld0 = 1; vld1 = 1; acc = 1;
      u0 = 6'(8'h20 + k); u1 = 6'(8'h30 + k);
      rd0 = 5'(k); rd1 = 5'(k + 16);
      #1;
      eu = (k == 0) ? 6'h0A : (k == 1) ? 6'h0C : 6'(8'h20 + k - 2);
      chk("cc_u0", ou0, eu);
      chk("cc_odr", odr, (k < 2) ? 2'b01 : 2'b11);
      chk("cc_cnt", cnt, 3'd2);
      step();
    end
    idle();
    chk("cc_end_cnt", cnt, 3'd2);
    chk("cc_end_u0", ou0, 6'h28);
    chk("cc_end_u1", ou1, 6'h38);
    chk("cc_end_rd0", ord0, 5'd8);
    chk("cc_end_rd1", ord1, 5'd24);

    // clear with pair and acc presented
    vld0 = 1; vld1 = 1; u0 = 6'h11; u1 = 6'h12; rd0 = 5'd1; rd1 = 5'd2;
    step();
    chk("pre_clr_cnt", cnt, 3'd3);
    clr = 1; acc = 1; vld0 = 1; vld1 = 0; u0 = 6'h2F; rd0 = 5'd7;
    #1;
    chk("clr_rdy", rdy, 1'b0);
    step();
    clr = 0; vld0 = 0;
    chk("clr_cnt", cnt, 3'd0);
    chk("clr_odr", odr, 2'b00);
    chk("clr_u0", ou0, 6'h3F);
    step();
    chk("empty_acc_cnt", cnt, 3'd0);
    idle();
    vld0 = 1; u0 = 6'h15; rd0 = 5'd3;
    step();
    idle();
    chk("post_u0", ou0, 6'h15);
    chk("post_odr", odr, 2'b01);
    chk("post_cnt", cnt, 3'd1);
    chk("post_u1", ou1, 6'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
